// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the iterative CORDIC engine.
// Latency: n/a (package). Backpressure: n/a.
// Holds the atan(2^-i) table at 32 fractional bits, pi/2, rounding and saturation helpers.
package cordic_pkg;

  // Controller states: IDLE -> FOLD -> ITER -> DONE -> IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Operating mode, sampled together with start.
  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // pi/2 scaled by 2^32, rounded to nearest.
  localparam logic [63:0] HALF_PI_32 = 64'd6746518852;

  // atan(2^-i) scaled by 2^32, rounded to nearest. From i = 11 upward the cubic
  // term is below half an LSB, so the entry is exactly 2^(32-i).
  function automatic logic [63:0] atan_tab32(input int i);
    case (i)
      0:       return 64'd3373259426;
      1:       return 64'd1991351318;
      2:       return 64'd1052175346;
      3:       return 64'd534100635;
      4:       return 64'd268086748;
      5:       return 64'd134174063;
      6:       return 64'd67103403;
      7:       return 64'd33553749;
      8:       return 64'd16777131;
      9:       return 64'd8388597;
      10:      return 64'd4194303;
      default: return 64'd1 << (32 - i);
    endcase
  endfunction

  // Round a 32-fractional-bit constant to frac fractional bits (frac <= 31).
  function automatic logic [63:0] round_frac(input logic [63:0] v32, input int frac);
    return (v32 + (64'd1 << (31 - frac))) >> (32 - frac);
  endfunction

  // Clamp a signed value to the range of a dw-bit two's complement word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_engine_if.sv
// Request/response bundle between the CORDIC engine and its caller.
// Latency: n/a (wiring only). Backpressure: start is honoured only while ready is high.
// master drives start/mode/x_in/y_in/z_in; slave returns ready/done/x_out/y_out/z_out.
interface cordic_engine_if
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 24
);
  logic                         start;
  mode_e                        mode;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic signed [DATA_WIDTH-1:0] z_in;
  logic                         ready;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic signed [DATA_WIDTH-1:0] z_out;

  modport master (
    output start, mode, x_in, y_in, z_in,
    input  ready, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in,
    output ready, done, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, scaled to FRAC_WIDTH fractional bits at DATA_WIDTH.
// Latency: 0 cycles. Backpressure: none (pure lookup).
// Ports: idx_i = iteration index 0..31, atan_o = rounded signed angle in radians.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_WIDTH = 21
) (
  input  logic [4:0]                   idx_i,
  output logic signed [DATA_WIDTH-1:0] atan_o
);

  assign atan_o = DATA_WIDTH'(round_frac(atan_tab32(int'(idx_i)), FRAC_WIDTH));

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC: rotation (sin/cos) or vectoring (atan2/magnitude), with quadrant pre-fold.
// Latency: done pulses ITERATIONS+1 enabled edges after the accepting edge; clk_en=0 freezes all state.
// Backpressure: ready is high only in IDLE; start while busy is dropped, nothing is queued.
// Ports: clk, rst (sync, active high), clk_en, bus (slave side of cordic_engine_if).
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_WIDTH = 21,
  parameter int ITERATIONS = 16,
  parameter int GUARD_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  cordic_engine_if.slave   bus
);

  localparam int W = DATA_WIDTH + GUARD_BITS;
  localparam logic [4:0] LAST_I = 5'(ITERATIONS - 1);
  localparam logic signed [DATA_WIDTH-1:0] HALF_PI =
    DATA_WIDTH'(round_frac(HALF_PI_32, FRAC_WIDTH));

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;

  logic signed [W-1:0]          x_q, x_d, y_q, y_d;
  logic signed [DATA_WIDTH-1:0] z_q, z_d;
  mode_e                        mode_q, mode_d;
  logic [4:0]                   i_q, i_d;
  logic signed [DATA_WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic signed [DATA_WIDTH-1:0] atan_val;
  logic signed [W-1:0]          x_sh, y_sh;
  logic                         dir_pos;

  cordic_atan_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_rom (
    .idx_i  (i_q),
    .atan_o (atan_val)
  );

  // ---------------- FSM: state register ----------------
  // rst wins over clk_en so a reset always lands in IDLE on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FOLD;
      S_FOLD: state_d = S_ITER;
      S_ITER: if (i_q == LAST_I) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // ready/done are registered decodes of the next state, so both change one
  // edge after the event that causes them.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // ---------------- Datapath ----------------
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  // Rotation drives z toward 0; vectoring drives y toward 0.
  assign dir_pos = (mode_q == MODE_ROT) ? ~z_q[DATA_WIDTH-1] : y_q[W-1];

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    mode_d = mode_q;
    i_d    = i_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    zo_d   = zo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d    = W'(bus.x_in);
          y_d    = W'(bus.y_in);
          z_d    = bus.z_in;
          mode_d = bus.mode;
        end
      end
      S_FOLD: begin
        i_d = 5'd0;
        // Pre-rotate by +/-pi/2 so the residual angle is inside the
        // convergence range of the micro-rotations (~1.74 rad).
        if (mode_q == MODE_ROT) begin
          if (z_q > HALF_PI) begin
            x_d = -y_q;
            y_d = x_q;
            z_d = z_q - HALF_PI;
          end else if (z_q < -HALF_PI) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = z_q + HALF_PI;
          end
        end else if (x_q[W-1]) begin
          if (!y_q[W-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = z_q + HALF_PI;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = z_q - HALF_PI;
          end
        end
      end
      S_ITER: begin
        if (dir_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_val;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_val;
        end
        i_d = i_q + 5'd1;
        if (i_q == LAST_I) begin
          xo_d = DATA_WIDTH'(sat_w(64'(x_d), DATA_WIDTH));
          yo_d = DATA_WIDTH'(sat_w(64'(y_d), DATA_WIDTH));
          zo_d = z_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      mode_q <= MODE_ROT;
      i_q    <= '0;
      xo_q   <= '0;
      yo_q   <= '0;
      zo_q   <= '0;
    end else if (clk_en) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      mode_q <= mode_d;
      i_q    <= i_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      zo_q   <= zo_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.x_out = xo_q;
  assign bus.y_out = yo_q;
  assign bus.z_out = zo_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: real-arithmetic reference model, directed cases
// plus randomized rotation/vectoring with random start noise and clk_en stalls.
module tb_cordic_engine;
  import cordic_pkg::*;

  localparam int  DW = 24;
  localparam int  FW = 21;
  localparam int  IT = 16;
  localparam int  GB = 2;
  localparam real SCALE = 2.0 ** FW;
  localparam real TOL_D = 2.0 ** (-14);
  localparam real TOL_R = 2.0 ** (-13);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  cordic_engine_if #(.DATA_WIDTH(DW)) bus ();

  cordic_engine #(
    .DATA_WIDTH (DW),
    .FRAC_WIDTH (FW),
    .ITERATIONS (IT),
    .GUARD_BITS (GB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  typedef struct {
    real ex, ey, ez, tol;
    bit  chk_y, chk_z;
    int  exp_en;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int edges = 0, en_edges = 0, n_done = 0, done_edge = 0, n_acc = 0;

  function automatic real to_r(input logic signed [DW-1:0] v);
    return real'(v) / SCALE;
  endfunction

  function automatic int q(input real r);
    return $rtoi(r * SCALE + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  task automatic check_real(input string nm, input real act, input real exp, input real tol);
    n_vec++;
    if (act - exp > tol || exp - act > tol) begin
      n_err++;
      $display("FAIL %s: got %f, want %f (tol %f) t=%0t", nm, act, exp, tol, $time);
    end
  endtask

  task automatic check_int(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Ideal CORDIC result: exact trig scaled by the n-iteration gain, then clamped.
  function automatic exp_t model(input bit vec, input real x, input real y, input real z);
    exp_t e;
    real k, hi, lo;
    k = 1.0;
    for (int i = 0; i < IT; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    if (!vec) begin
      e.ex = k * (x * $cos(z) - y * $sin(z));
      e.ey = k * (x * $sin(z) + y * $cos(z));
      e.ez = 0.0;
    end else begin
      e.ex = k * $sqrt(x * x + y * y);
      e.ey = 0.0;
      e.ez = (x == 0.0 && y == 0.0) ? 0.0 : z + $atan2(y, x);
    end
    hi = (2.0 ** (DW - 1) - 1.0) / SCALE;
    lo = -(2.0 ** (DW - 1)) / SCALE;
    if (e.ex > hi) e.ex = hi;
    if (e.ex < lo) e.ex = lo;
    if (e.ey > hi) e.ey = hi;
    if (e.ey < lo) e.ey = lo;
    return e;
  endfunction

  // Monitor: a done seen after an enabled edge is a new result.
  initial begin : monitor
    exp_t e;
    bit   edge_en;
    forever begin
      @(posedge clk);
      edge_en = clk_en && !rst;
      #1;
      edges++;
      if (edge_en) en_edges++;
      if (edge_en && bus.done) begin
        n_done++;
        done_edge = edges;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done with empty scoreboard, want none t=%0t", $time);
        end else begin
          e = sb.pop_front();
          check_real("x_out", to_r(bus.x_out), e.ex, e.tol);
          if (e.chk_y) check_real("y_out", to_r(bus.y_out), e.ey, e.tol);
          if (e.chk_z) check_real("z_out", to_r(bus.z_out), e.ez, e.tol);
          check_int("latency_en", en_edges, e.exp_en);
        end
      end
    end
  end

  // One operation. ns: random start pulses while busy; ne: random clk_en;
  // stall_after/stall_len: deterministic clk_en gap once that many enabled
  // edges (counting the accepting edge) have passed; rst_after: reset there.
  task automatic run_op(input bit vec, input int xi, input int yi, input int zi,
                        input real tol, input bit chk_y, input bit chk_z,
                        input int stall_after, input int stall_len,
                        input bit ns, input bit ne, input int rst_after);
    exp_t e;
    int   acc_edge, done0, en_cnt, stalled, cyc;
    bit   en_now;
    @(negedge clk);
    check_int("ready_idle", bus.ready, 1);
    clk_en    = 1'b1;
    bus.start = 1'b1;
    bus.mode  = vec ? MODE_VEC : MODE_ROT;
    bus.x_in  = DW'(xi);
    bus.y_in  = DW'(yi);
    bus.z_in  = DW'(zi);
    e = model(vec, real'(xi) / SCALE, real'(yi) / SCALE, real'(zi) / SCALE);
    e.tol = tol;
    e.chk_y = chk_y;
    e.chk_z = chk_z;
    e.exp_en = en_edges + IT + 2;
    sb.push_back(e);
    acc_edge = edges + 1;
    done0 = n_done;
    @(negedge clk);
    bus.start = 1'b0;
    check_int("ready_busy", bus.ready, 0);
    en_cnt = 1;
    stalled = 0;
    cyc = 0;
    while (n_done == done0 && cyc < 200) begin
      if (rst_after >= 0 && en_cnt == rst_after) begin
        clk_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check_int("rst_ready", bus.ready, 1);
        check_int("rst_done", bus.done, 0);
        check_int("rst_x_out", bus.x_out, 0);
        check_int("rst_y_out", bus.y_out, 0);
        check_int("rst_z_out", bus.z_out, 0);
        return;
      end
      if (ne) clk_en = ($urandom_range(0, 3) != 0);
      else if (en_cnt == stall_after && stalled < stall_len) begin
        clk_en = 1'b0;
        stalled++;
      end else clk_en = 1'b1;
      if (ns) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mode  = mode_e'($urandom_range(0, 1));
        bus.x_in  = DW'($urandom);
        bus.y_in  = DW'($urandom);
        bus.z_in  = DW'($urandom);
      end
      en_now = clk_en;
      @(negedge clk);
      cyc++;
      if (en_now) en_cnt++;
    end
    bus.start = 1'b0;
    clk_en = 1'b1;
    if (n_done == done0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, want one t=%0t", cyc, $time);
      void'(sb.pop_back());
    end else begin
      n_acc++;
      if (!ne) check_int("latency_abs", done_edge - acc_edge, IT + 1 + stall_len);
    end
  endtask

  // done and ready must freeze while clk_en is low right after a result.
  task automatic freeze_check();
    clk_en = 1'b0;
    @(negedge clk);
    check_int("hold_done", bus.done, 1);
    check_int("hold_ready", bus.ready, 0);
    clk_en = 1'b1;
    @(negedge clk);
    check_int("after_done", bus.done, 0);
    check_int("after_ready", bus.ready, 1);
  endtask

  initial begin : driver
    int xi, yi, zi;
    int c7 = q(0.607253);
    rst = 1'b1;
    clk_en = 1'b1;
    bus.start = 1'b0;
    bus.mode = MODE_ROT;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.z_in = '0;
    repeat (3) @(negedge clk);
    check_int("reset_ready", bus.ready, 1);
    check_int("reset_done", bus.done, 0);
    check_int("reset_x_out", bus.x_out, 0);
    check_int("reset_y_out", bus.y_out, 0);
    check_int("reset_z_out", bus.z_out, 0);
    rst = 1'b0;

    run_op(0, c7, 0, q(0.523599), TOL_D, 1, 1, -1, 0, 0, 0, -1);
    freeze_check();
    run_op(0, c7, 0, q(2.617994), TOL_D, 1, 1, -1, 0, 0, 0, -1);
    run_op(1, q(-0.5), q(-0.5), 0, TOL_D, 1, 1, -1, 0, 0, 0, -1);
    run_op(0, c7, 0, q(0.523599), TOL_D, 1, 1, -1, 0, 1, 0, -1);
    run_op(0, c7, 0, q(0.523599), TOL_D, 1, 1, 10, 5, 0, 0, -1);
    run_op(0, c7, 0, q(0.523599), TOL_D, 1, 1, -1, 0, 0, 0, 10);
    run_op(0, c7, 0, q(0.523599), TOL_D, 1, 1, -1, 0, 0, 0, -1);
    run_op(1, q(3.9), q(3.9), 0, TOL_D, 0, 1, -1, 0, 0, 0, -1);
    run_op(0, c7, q(0.1), q(PI / 2.0), TOL_D, 1, 1, -1, 0, 0, 0, -1);
    run_op(0, c7, q(-0.1), -q(PI / 2.0), TOL_D, 1, 1, -1, 0, 0, 0, -1);
    run_op(1, 0, 0, 0, TOL_D, 1, 0, -1, 0, 0, 0, -1);
    run_op(1, q(-0.75), 0, 0, TOL_D, 1, 1, -1, 0, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      xi = int'($urandom_range(0, 2 * q(0.6))) - q(0.6);
      yi = int'($urandom_range(0, 2 * q(0.6))) - q(0.6);
      zi = int'($urandom_range(0, 2 * q(3.14))) - q(3.14);
      run_op(0, xi, yi, zi, TOL_R, 1, 1, -1, 0, 1, 1, -1);
    end
    for (int n = 0; n < 24; n++) begin
      do begin
        xi = int'($urandom_range(0, 2 * q(1.0))) - q(1.0);
        yi = int'($urandom_range(0, 2 * q(1.0))) - q(1.0);
      end while ((real'(xi) / SCALE) ** 2 + (real'(yi) / SCALE) ** 2 < 0.0625);
      zi = int'($urandom_range(0, 2 * q(0.5))) - q(0.5);
      run_op(1, xi, yi, zi, TOL_R, 1, 1, -1, 0, 1, 1, -1);
    end

    repeat (4) @(negedge clk);
    check_int("sb_empty", sb.size(), 0);
    check_int("done_count", n_done, n_acc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
# cordic_engine

- Parametrised, iterative fixed-point CORDIC engine with two runtime-selectable modes:
  - rotation: sin/cos of an angle.
  - vectoring: atan2 and magnitude of a vector.
- Successor to the single-mode, fixed-width cordic block: full ±π range via quadrant pre-folding, configurable width and iteration count, saturating outputs, and a start/ready/done handshake.
- Sits between the float↔fixed converters and the bus-facing wrapper; all I/O is signed fixed point.

## Interface
Parameters:
- DATA_WIDTH, 24 — I/O word width, signed two's complement.
- FRAC_WIDTH, 21 — fractional bits; default format is Q3.21, range ±4.0.
- ITERATIONS, 16 — micro-rotations; legal range 1..min(32, FRAC_WIDTH+1).
- GUARD_BITS, 2 — extra integer bits on internal x/y.

Ports:
- clk — in, 1 — clock; single clock domain.
- rst — in, 1 — synchronous, active-high reset.
- clk_en — in, 1 — when 0, all state holds.
- start — in, 1 — request; accepted only when ready=1 and clk_en=1.
- mode — in, 1 — 0 = rotation, 1 = vectoring; sampled with start.
- x_in, y_in, z_in — in, DATA_WIDTH each — initial vector and angle in radians; sampled with start.
- ready — out, 1 — high in IDLE only.
- done — out, 1 — one-cycle pulse; outputs valid while high.
- x_out, y_out, z_out — out, DATA_WIDTH each — results; held until the next accepted start or rst.

## Operation
- States: IDLE → FOLD → ITER → DONE → IDLE.
- IDLE: on start, register x_in/y_in sign-extended to DATA_WIDTH+GUARD_BITS, z_in, and mode. Go to FOLD.
- FOLD: quadrant pre-rotation, one cycle.
  - Rotation, z > π/2: x ← −y, y ← x, z ← z − π/2.
  - Rotation, z < −π/2: x ← y, y ← −x, z ← z + π/2.
  - Vectoring, x < 0 and y ≥ 0: x ← y, y ← −x, z ← z + π/2.
  - Vectoring, x < 0 and y < 0: x ← −y, y ← x, z ← z − π/2.
  - All other cases: unchanged.
  - Clear iteration counter i. Go to ITER.
- ITER: one micro-rotation per enabled cycle.
  - Direction d = +1 when (rotation and z ≥ 0) or (vectoring and y < 0); otherwise d = −1.
  - Updates: x ← x − d·(y >>> i), y ← y + d·(x >>> i), z ← z − d·atan(2^−i).
  - `>>>` is an arithmetic shift, truncating.
  - After iteration i = ITERATIONS−1, latch the outputs and go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- No gain compensation; outputs carry K ≈ 1.64676.
  - For unit-scaled cos/sin in rotation mode, drive x_in = 1/K ≈ 0.607253.
- Output conversion: x/y saturate from internal width to DATA_WIDTH (max 2^(DATA_WIDTH−1)−1, min −2^(DATA_WIDTH−1)). z is not saturated; it cannot overflow for legal inputs.
- Boundary conditions:
  - start with ready = 0 is ignored; no queueing.
  - start and clk_en = 0 in the same cycle is not accepted.
  - rst at any point, mid-operation included, forces IDLE the next cycle; any result in progress is lost.
  - z_in outside ±π in rotation mode: FOLD folds once only, so the result is undefined. This is the caller's responsibility.
  - z = exactly ±π/2 in rotation mode: not folded.
  - Vectoring with x = y = 0 gives x_out = 0 and y_out = 0; z_out is don't-care.

## Timing
- Reset values:
  - ready = 1, done = 0.
  - x_out, y_out, z_out = 0.
  - Internal registers = 0; state = IDLE.
- Latency: start accepted at edge N → done high in the cycle after edge N+1+ITERATIONS (ITERATIONS+2 edges). Default is 18.
- Each clk_en = 0 cycle adds exactly one cycle of latency. done, ready and the outputs freeze during those cycles.
- Throughput: one operation per ITERATIONS+3 cycles.
- ready is a registered decode of state. It drops the cycle after the start that was accepted.

## Structure
- Package cordic_pkg:
  - 32-entry atan(2^−i) table at 32 fractional bits, plus π/2, rounded to FRAC_WIDTH by a package function.
  - State enum and mode constants.
  - Saturation function.
- Sub-module cordic_atan_rom: combinational, indexed by i, output FRAC_WIDTH-scaled at DATA_WIDTH.
- The shifters and add/sub logic live inline in cordic_engine.

## Test plan
All values are in Q3.21 at default parameters. Tolerance is ±2^−14 unless stated.
1. Rotation, x = 0.607253, y = 0, z = 0.523599 (π/6) → x_out ≈ 0.866025, y_out ≈ 0.5, z_out ≈ 0. done arrives at edge 18.
2. Rotation, x = 0.607253, y = 0, z = 2.617994 (5π/6) → x_out ≈ −0.866025, y_out ≈ 0.5. Exercises FOLD.
3. Vectoring, x = −0.5, y = −0.5, z = 0 → z_out ≈ −2.356194, x_out ≈ 1.164450, |y_out| < 2^−14.
4. Handshake and stall:
   - start pulses during ITER are ignored; exactly one done per accepted start.
   - clk_en low for 5 cycles at iteration 8 → done at edge 23, with results identical to scenario 1.
5. rst asserted at iteration 8 → next cycle ready = 1, done = 0, outputs = 0. A following start of scenario 1 completes with identical results.
6. Vectoring, x = y = 3.9 → x_out saturates to 0x7FFFFF (3.99999952), and z_out ≈ 0.785398.
